gmii_tx_framer: RTL and testbench

//  Transmit-side egress stage of each bridge port: takes the packet stream leaving the

---
 rtl/gmii_tx_framer_pkg.sv | 39 +++
 rtl/gmii_tx_framer_if.sv | 38 +++
 rtl/gmii_tx_framer.sv | 226 ++++++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_tx_framer_pkg
//  Description : Shared definitions for the GMII transmit framer: PCC byte
//                codes carried alongside the output-FIFO byte stream, GMII
//                framing constants and the saturating byte-count helper.
//  Revision    : 1.0  initial release
// ============================================================================
package gmii_tx_framer_pkg;

    // PCC codes tagging each byte leaving the port output FIFO
    typedef logic [1:0] pcc_code_t;

    localparam pcc_code_t PCC_DATA   = 2'b00;
    localparam pcc_code_t PCC_SOP    = 2'b01;
    localparam pcc_code_t PCC_EOP    = 2'b10;
    localparam pcc_code_t PCC_BADEOP = 2'b11;

    // GMII framing
    localparam logic [7:0] GMII_PREAMBLE = 8'h55;
    localparam logic [7:0] GMII_SFD      = 8'hD5;

    // Minimum number of data bytes in a padded frame
    localparam int MIN_FRAME = 60;

    // Data-byte counter width; the counter sticks at its maximum value
    localparam int BYTE_CNT_W = 11;

    function automatic logic [BYTE_CNT_W-1:0] byte_cnt_inc(
        input logic [BYTE_CNT_W-1:0] cnt
    );
        if (&cnt) begin
            return cnt;
        end
        return cnt + BYTE_CNT_W'(1);
    endfunction

endpackage : gmii_tx_framer_pkg
`default_nettype wire

// File: rtl/gmii_tx_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_tx_framer_if
//  Description : srdy/drdy byte stream from the port output FIFO into the
//                GMII transmit framer.
//                  txf_srdy  byte valid (FIFO side)
//                  txf_drdy  byte accepted this cycle (framer side)
//                  txf_data  byte value
//                  txf_code  PCC code: DATA / SOP / EOP / BADEOP
//                A byte moves when txf_srdy & txf_drdy on a rising clk edge.
//  Revision    : 1.0  initial release
// ============================================================================
interface gmii_tx_framer_if;
    import gmii_tx_framer_pkg::*;

    logic       txf_srdy;
    logic       txf_drdy;
    logic [7:0] txf_data;
    pcc_code_t  txf_code;

    // FIFO side
    modport master (
        output txf_srdy,
        output txf_data,
        output txf_code,
        input  txf_drdy
    );

    // Framer side
    modport slave (
        input  txf_srdy,
        input  txf_data,
        input  txf_code,
        output txf_drdy
    );

endinterface : gmii_tx_framer_if
`default_nettype wire

// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_tx_framer
//  Description : Egress stage of a bridge port. Takes the PCC-coded byte stream
//                leaving the port output FIFO and drives GMII TX: inserts
//                preamble + SFD, enforces the inter-frame gap, flags underrun,
//                bad EOP and protocol errors.
//  Parameters  : IFG_CYCLES  idle cycles between frames (>=1)
//                PRE_BYTES   0x55 bytes ahead of the SFD (>=1)
//  Macro       : GMII_TX_PAD_EN - when defined, clean frames shorter than
//                MIN_FRAME data bytes are padded with 0x00.
//  Ports       : clk           system clock, rising edge
//                reset         asynchronous active-low reset
//                txf           byte stream in (slave modport)
//                gmii_tx_en    GMII transmit enable     (registered)
//                gmii_txd      GMII transmit data       (registered)
//                gmii_tx_er    GMII transmit error      (registered)
//                tx_done       frame completed cleanly  (1-cycle pulse)
//                tx_underrun   source starved mid-frame (1-cycle pulse)
//                tx_proto_err  out-of-place SOP/non-SOP (1-cycle pulse)
//  Revision    : 1.0  initial release
// ============================================================================
module gmii_tx_framer
    import gmii_tx_framer_pkg::*;
#(
    parameter int IFG_CYCLES = 12,
    parameter int PRE_BYTES  = 7
) (
    input  wire logic            clk,
    input  wire logic            reset,
    gmii_tx_framer_if.slave      txf,
    output logic                 gmii_tx_en,
    output logic [7:0]           gmii_txd,
    output logic                 gmii_tx_er,
    output logic                 tx_done,
    output logic                 tx_underrun,
    output logic                 tx_proto_err
);

    localparam int c_PRE_W = $clog2(PRE_BYTES + 1);
    localparam int c_IFG_W = $clog2(IFG_CYCLES + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRE_BYTES);
    localparam logic [c_IFG_W-1:0] c_IFG_LAST = c_IFG_W'(IFG_CYCLES - 1);
`ifdef GMII_TX_PAD_EN
    localparam logic [BYTE_CNT_W-1:0] c_MIN_FRAME = BYTE_CNT_W'(MIN_FRAME);
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SFD   = 3'd2,
        ST_DATA  = 3'd3,
`ifdef GMII_TX_PAD_EN
        ST_PAD   = 3'd6,
`endif
        ST_DRAIN = 3'd4,
        ST_IFG   = 3'd5
    } state_t;

    state_t                  r_state;
    logic [c_PRE_W-1:0]      r_pre_cnt;
    logic [c_IFG_W-1:0]      r_ifg_cnt;
    logic [BYTE_CNT_W-1:0]   r_byte_cnt;
    logic                    r_tx_en;
    logic [7:0]              r_txd;
    logic                    r_tx_er;
    logic                    r_tx_done;
    logic                    r_underrun;
    logic                    r_proto_err;

    logic [BYTE_CNT_W-1:0]   w_byte_cnt_inc;
    logic                    w_drdy;

    assign w_byte_cnt_inc = byte_cnt_inc(r_byte_cnt);

    // drdy depends on state (and, in IDLE, on the head code) but never on srdy.
    // It is high exactly in the cycles whose consumed byte becomes the next
    // registered txd, plus IDLE junk discard and the post-underrun drain.
    always_comb begin
        w_drdy = 1'b0;
        if (reset) begin
            case (r_state)
                ST_IDLE:                     w_drdy = (txf.txf_code != PCC_SOP);
                ST_SFD, ST_DATA, ST_DRAIN:   w_drdy = 1'b1;
                default:                     w_drdy = 1'b0;
            endcase
        end
    end

    assign txf.txf_drdy = w_drdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_pre_cnt   <= '0;
            r_ifg_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_tx_en     <= 1'b0;
            r_txd       <= 8'h00;
            r_tx_er     <= 1'b0;
            r_tx_done   <= 1'b0;
            r_underrun  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            // Idle line and pulses low unless a state below drives them
            r_tx_en     <= 1'b0;
            r_txd       <= 8'h00;
            r_tx_er     <= 1'b0;
            r_tx_done   <= 1'b0;
            r_underrun  <= 1'b0;
            r_proto_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // SOP is left in the FIFO; it is consumed in the SFD cycle
                    if (txf.txf_srdy) begin
                        if (txf.txf_code == PCC_SOP) begin
                            r_state   <= ST_PRE;
                            r_pre_cnt <= c_PRE_W'(1);
                            r_tx_en   <= 1'b1;
                            r_txd     <= GMII_PREAMBLE;
                        end else begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end

                ST_PRE: begin
                    r_tx_en <= 1'b1;
                    if (r_pre_cnt == c_PRE_LAST) begin
                        r_txd   <= GMII_SFD;
                        r_state <= ST_SFD;
                    end else begin
                        r_txd     <= GMII_PREAMBLE;
                        r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
                    end
                end

                // SFD is on the wire: the byte taken now is the first data byte
                ST_SFD, ST_DATA: begin
                    r_tx_en <= 1'b1;
                    if (txf.txf_srdy) begin
                        r_txd <= txf.txf_data;
                        if (txf.txf_code == PCC_SOP) begin
                            r_byte_cnt  <= BYTE_CNT_W'(1);
                            r_proto_err <= (r_state == ST_DATA);
                        end else begin
                            r_byte_cnt  <= w_byte_cnt_inc;
                        end
                        case (txf.txf_code)
                            PCC_EOP: begin
`ifdef GMII_TX_PAD_EN
                                if (w_byte_cnt_inc < c_MIN_FRAME) begin
                                    r_state <= ST_PAD;
                                end else begin
                                    r_tx_done <= 1'b1;
                                    r_state   <= ST_IFG;
                                end
`else
                                r_tx_done <= 1'b1;
                                r_state   <= ST_IFG;
`endif
                            end
                            PCC_BADEOP: begin
                                r_tx_er <= 1'b1;
                                r_state <= ST_IFG;
                            end
                            default: begin
                                r_state <= ST_DATA;
                            end
                        endcase
                    end else begin
                        // Source starved: one error byte, then drop the rest
                        r_txd      <= 8'h00;
                        r_tx_er    <= 1'b1;
                        r_underrun <= 1'b1;
                        r_state    <= ST_DRAIN;
                    end
                end

`ifdef GMII_TX_PAD_EN
                ST_PAD: begin
                    r_tx_en    <= 1'b1;
                    r_byte_cnt <= w_byte_cnt_inc;
                    if (w_byte_cnt_inc >= c_MIN_FRAME) begin
                        r_tx_done <= 1'b1;
                        r_state   <= ST_IFG;
                    end
                end
`endif

                ST_DRAIN: begin
                    if (txf.txf_srdy &&
                        ((txf.txf_code == PCC_EOP) || (txf.txf_code == PCC_BADEOP))) begin
                        r_state <= ST_IFG;
                    end
                end

                // Entered during the last tx_en=1 cycle; IDLE is reached so that
                // the first preamble byte lands IFG_CYCLES idle cycles later.
                ST_IFG: begin
                    if (r_ifg_cnt == c_IFG_LAST) begin
                        r_ifg_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + c_IFG_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gmii_tx_en   = r_tx_en;
    assign gmii_txd     = r_txd;
    assign gmii_tx_er   = r_tx_er;
    assign tx_done      = r_tx_done;
    assign tx_underrun  = r_underrun;
    assign tx_proto_err = r_proto_err;

endmodule : gmii_tx_framer
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmii_tx_framer
//  Description : Directed self-checking bench for gmii_tx_framer. A source
//                process plays a byte queue onto the srdy/drdy stream; a
//                monitor records every tx_en=1 byte, frame lengths, gaps and
//                pulses; one task per scenario compares against hand-derived
//                expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gmii_tx_framer;
    import gmii_tx_framer_pkg::*;

    localparam int IFG = 12;
    localparam int PRE = 7;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tx_en;
    logic [7:0] txd;
    logic       tx_er;
    logic       tx_done;
    logic       tx_underrun;
    logic       tx_proto_err;

    gmii_tx_framer_if u_if ();

    gmii_tx_framer #(
        .IFG_CYCLES (IFG),
        .PRE_BYTES  (PRE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .txf          (u_if.slave),
        .gmii_tx_en   (tx_en),
        .gmii_txd     (txd),
        .gmii_tx_er   (tx_er),
        .tx_done      (tx_done),
        .tx_underrun  (tx_underrun),
        .tx_proto_err (tx_proto_err)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- source ----------------
    logic [9:0] src_q[$];
    int         src_rd = 0;
    bit         drv_fire;

    initial begin
        u_if.txf_srdy = 1'b0;
        u_if.txf_data = 8'h00;
        u_if.txf_code = PCC_DATA;
        forever begin
            @(negedge clk);
            if (src_rd < src_q.size()) begin
                u_if.txf_srdy = 1'b1;
                u_if.txf_code = src_q[src_rd][9:8];
                u_if.txf_data = src_q[src_rd][7:0];
            end else begin
                u_if.txf_srdy = 1'b0;
                u_if.txf_code = PCC_DATA;
                u_if.txf_data = 8'h00;
            end
            #1;
            drv_fire = u_if.txf_srdy && u_if.txf_drdy;
            @(posedge clk);
            if (drv_fire) src_rd++;
        end
    end

    // ---------------- monitor ----------------
    int         cyc = 0;
    logic [8:0] rx_q[$];
    int         len_q[$];
    int         gap_q[$];
    int         done_q[$];
    int         under_q[$];
    int         n_done = 0, n_under = 0, n_proto = 0, n_idle_bad = 0;
    bit         prev_en = 1'b0;
    int         rise_cyc = 0;
    int         last_en_cyc = -1;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (tx_en) begin
            if (!prev_en) begin
                rise_cyc = cyc;
                if (last_en_cyc >= 0) gap_q.push_back(cyc - last_en_cyc - 1);
            end
            rx_q.push_back({tx_er, txd});
            last_en_cyc = cyc;
        end else begin
            if (prev_en) len_q.push_back(cyc - rise_cyc);
            if (txd !== 8'h00 || tx_er !== 1'b0) n_idle_bad++;
        end
        if (tx_done) begin
            n_done++;
            done_q.push_back(tx_en ? rx_q.size() - 1 : -1);
        end
        if (tx_underrun) begin
            n_under++;
            under_q.push_back(tx_en ? rx_q.size() - 1 : -1);
        end
        if (tx_proto_err) n_proto++;
        prev_en = tx_en;
    end

    // ---------------- helpers ----------------
    // byte i = seed+i; first byte SOP if first_sop, last byte last_code
    task automatic push_seq(input logic [7:0] seed, input int n,
                            input bit first_sop, input logic [1:0] last_code);
        for (int i = 0; i < n; i++) begin
            logic [1:0] c;
            c = PCC_DATA;
            if (i == 0 && first_sop) c = PCC_SOP;
            else if (i == n - 1)     c = last_code;
            src_q.push_back({c, 8'(seed + 8'(i))});
        end
    endtask

    task automatic wait_len(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (len_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (tx_en !== 1'b0)        begin n_bad++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        n_cmp++; if (txd !== 8'h00)         begin n_bad++; $display("FAIL reset_txd: got %h want 00", txd); end
        n_cmp++; if (tx_er !== 1'b0)        begin n_bad++; $display("FAIL reset_tx_er: got %b want 0", tx_er); end
        n_cmp++; if (u_if.txf_drdy !== 1'b0) begin n_bad++; $display("FAIL reset_drdy: got %b want 0", u_if.txf_drdy); end
        n_cmp++; if ({tx_done, tx_underrun, tx_proto_err} !== 3'b000)
            begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {tx_done, tx_underrun, tx_proto_err}); end
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #1;
        // IDLE with a non-SOP code at the head: ready to discard
        n_cmp++; if (u_if.txf_drdy !== 1'b1) begin n_bad++; $display("FAIL idle_drdy: got %b want 1", u_if.txf_drdy); end
        n_cmp++; if (tx_en !== 1'b0)         begin n_bad++; $display("FAIL idle_tx_en: got %b want 0", tx_en); end
    endtask

    task automatic test_basic;
        int base, lbase, d0, u0, p0, exp_len;
        bit ok;
        base = rx_q.size(); lbase = len_q.size();
        d0 = n_done; u0 = n_under; p0 = n_proto;
`ifdef GMII_TX_PAD_EN
        exp_len = 68;
`else
        exp_len = 28;
`endif
        push_seq(8'h10, 20, 1'b1, PCC_EOP);
        wait_len(lbase + 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout: got no frame end want frame end"); end
        if (ok) begin
            n_cmp++; if (len_q[lbase] !== exp_len)
                begin n_bad++; $display("FAIL basic_len: got %0d want %0d", len_q[lbase], exp_len); end
            for (int i = 0; i < PRE; i++) begin
                n_cmp++; if (rx_q[base+i] !== 9'h055)
                    begin n_bad++; $display("FAIL basic_pre[%0d]: got %h want 055", i, rx_q[base+i]); end
            end
            n_cmp++; if (rx_q[base+7] !== 9'h0D5)
                begin n_bad++; $display("FAIL basic_sfd: got %h want 0D5", rx_q[base+7]); end
            for (int i = 0; i < 20; i++) begin
                n_cmp++; if (rx_q[base+8+i] !== {1'b0, 8'(8'h10 + 8'(i))})
                    begin n_bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, rx_q[base+8+i], {1'b0, 8'(8'h10 + 8'(i))}); end
            end
`ifdef GMII_TX_PAD_EN
            for (int i = 0; i < 40; i++) begin
                n_cmp++; if (rx_q[base+28+i] !== 9'h000)
                    begin n_bad++; $display("FAIL basic_pad[%0d]: got %h want 000", i, rx_q[base+28+i]); end
            end
`endif
            n_cmp++; if (n_done - d0 !== 1)
                begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", n_done - d0); end
            n_cmp++; if (done_q[done_q.size()-1] !== base + exp_len - 1)
                begin n_bad++; $display("FAIL basic_done_pos: got %0d want %0d", done_q[done_q.size()-1], base + exp_len - 1); end
            n_cmp++; if ((n_under - u0) + (n_proto - p0) !== 0)
                begin n_bad++; $display("FAIL basic_err_pulses: got %0d want 0", (n_under - u0) + (n_proto - p0)); end
        end
    endtask

    task automatic test_back_to_back;
        int base, lbase, d0;
        bit ok;
        base = rx_q.size(); lbase = len_q.size(); d0 = n_done;
        push_seq(8'h40, 64, 1'b1, PCC_EOP);
        push_seq(8'h80, 64, 1'b1, PCC_EOP);
        wait_len(lbase + 2, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got fewer than 2 frames want 2"); end
        if (ok) begin
            n_cmp++; if (len_q[lbase] !== 72)   begin n_bad++; $display("FAIL b2b_len0: got %0d want 72", len_q[lbase]); end
            n_cmp++; if (len_q[lbase+1] !== 72) begin n_bad++; $display("FAIL b2b_len1: got %0d want 72", len_q[lbase+1]); end
            n_cmp++; if (gap_q[gap_q.size()-1] !== IFG)
                begin n_bad++; $display("FAIL b2b_gap: got %0d want %0d", gap_q[gap_q.size()-1], IFG); end
            n_cmp++; if (n_done - d0 !== 2) begin n_bad++; $display("FAIL b2b_done_cnt: got %0d want 2", n_done - d0); end
            n_cmp++; if (rx_q[base+72+8] !== 9'h080)
                begin n_bad++; $display("FAIL b2b_f1_first: got %h want 080", rx_q[base+72+8]); end
            n_cmp++; if (rx_q[base+72+71] !== 9'h0BF)
                begin n_bad++; $display("FAIL b2b_f1_last: got %h want 0BF", rx_q[base+72+71]); end
        end
    endtask

    task automatic test_underrun;
        int base, lbase, d0, u0;
        bit ok;
        base = rx_q.size(); lbase = len_q.size(); d0 = n_done; u0 = n_under;
        push_seq(8'h20, 10, 1'b1, PCC_DATA);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (n_under != u0) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL under_timeout: got no underrun want pulse"); end
        push_seq(8'h2A, 54, 1'b0, PCC_EOP);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (src_rd == src_q.size()) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL under_drain: got %0d left want 0", src_q.size() - src_rd); end
        repeat (20) @(negedge clk);
        #1;
        n_cmp++; if (len_q.size() !== lbase + 1)
            begin n_bad++; $display("FAIL under_frames: got %0d want %0d", len_q.size(), lbase + 1); end
        n_cmp++; if (len_q[lbase] !== 19) begin n_bad++; $display("FAIL under_len: got %0d want 19", len_q[lbase]); end
        n_cmp++; if (rx_q[base+8] !== 9'h020)  begin n_bad++; $display("FAIL under_first: got %h want 020", rx_q[base+8]); end
        n_cmp++; if (rx_q[base+17] !== 9'h029) begin n_bad++; $display("FAIL under_byte10: got %h want 029", rx_q[base+17]); end
        n_cmp++; if (rx_q[base+18] !== 9'h100) begin n_bad++; $display("FAIL under_errbyte: got %h want 100", rx_q[base+18]); end
        n_cmp++; if (n_under - u0 !== 1) begin n_bad++; $display("FAIL under_cnt: got %0d want 1", n_under - u0); end
        n_cmp++; if (under_q[under_q.size()-1] !== base + 18)
            begin n_bad++; $display("FAIL under_pos: got %0d want %0d", under_q[under_q.size()-1], base + 18); end
        n_cmp++; if (n_done - d0 !== 0) begin n_bad++; $display("FAIL under_done: got %0d want 0", n_done - d0); end
    endtask

    task automatic test_badeop;
        int base, lbase, d0;
        bit ok;
        base = rx_q.size(); lbase = len_q.size(); d0 = n_done;
        push_seq(8'h60, 6, 1'b1, PCC_BADEOP);
        wait_len(lbase + 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bad_timeout: got no frame end want frame end"); end
        if (ok) begin
            n_cmp++; if (len_q[lbase] !== 14) begin n_bad++; $display("FAIL bad_len: got %0d want 14", len_q[lbase]); end
            n_cmp++; if (rx_q[base+12] !== 9'h064) begin n_bad++; $display("FAIL bad_prev: got %h want 064", rx_q[base+12]); end
            n_cmp++; if (rx_q[base+13] !== 9'h165) begin n_bad++; $display("FAIL bad_last: got %h want 165", rx_q[base+13]); end
            n_cmp++; if (n_done - d0 !== 0) begin n_bad++; $display("FAIL bad_done: got %0d want 0", n_done - d0); end
        end
    endtask

    task automatic test_proto;
        int base, lbase, d0, p0;
        bit ok;
        repeat (IFG + 4) @(negedge clk);
        base = rx_q.size(); lbase = len_q.size(); d0 = n_done; p0 = n_proto;
        push_seq(8'hE0, 3, 1'b0, PCC_DATA);
        push_seq(8'h90, 64, 1'b1, PCC_EOP);
        wait_len(lbase + 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL proto_timeout: got no frame end want frame end"); end
        if (ok) begin
            n_cmp++; if (n_proto - p0 !== 3) begin n_bad++; $display("FAIL proto_cnt: got %0d want 3", n_proto - p0); end
            n_cmp++; if (len_q[lbase] !== 72) begin n_bad++; $display("FAIL proto_len: got %0d want 72", len_q[lbase]); end
            n_cmp++; if (rx_q[base+8] !== 9'h090)  begin n_bad++; $display("FAIL proto_first: got %h want 090", rx_q[base+8]); end
            n_cmp++; if (rx_q[base+71] !== 9'h0CF) begin n_bad++; $display("FAIL proto_last: got %h want 0CF", rx_q[base+71]); end
            n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL proto_done: got %0d want 1", n_done - d0); end
        end
    endtask

    task automatic test_reset_mid;
        int base, lbase, d0, rel;
        bit ok;
        repeat (IFG + 4) @(negedge clk);
        base = rx_q.size(); lbase = len_q.size(); d0 = n_done;
        push_seq(8'hB0, 64, 1'b1, PCC_EOP);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (rx_q.size() >= base + 4) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_timeout: got no preamble want preamble"); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({tx_en, txd, tx_er} !== 10'h000)
            begin n_bad++; $display("FAIL rstmid_async: got %h want 000", {tx_en, txd, tx_er}); end
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        rel = cyc;
        wait_len(lbase + 2, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_timeout2: got no restart want frame"); end
        if (ok) begin
            n_cmp++; if (len_q[lbase] !== 4)    begin n_bad++; $display("FAIL rstmid_trunc: got %0d want 4", len_q[lbase]); end
            n_cmp++; if (rise_cyc !== rel + 2)  begin n_bad++; $display("FAIL rstmid_restart: got %0d want %0d", rise_cyc, rel + 2); end
            n_cmp++; if (len_q[lbase+1] !== 72) begin n_bad++; $display("FAIL rstmid_len: got %0d want 72", len_q[lbase+1]); end
            n_cmp++; if (rx_q[base+4+8] !== 9'h0B0) begin n_bad++; $display("FAIL rstmid_first: got %h want 0B0", rx_q[base+4+8]); end
            n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL rstmid_done: got %0d want 1", n_done - d0); end
        end
    endtask

    task automatic test_idle_clean;
        repeat (IFG + 4) @(negedge clk);
        #1;
        n_cmp++; if (n_idle_bad !== 0)
            begin n_bad++; $display("FAIL idle_clean: got %0d bad idle cycles want 0", n_idle_bad); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_underrun;
        test_badeop;
        test_proto;
        test_reset_mid;
        test_idle_clean;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_gmii_tx_framer
`default_nettype wire
